// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller with prescaler, dead time,
// frame-synchronous shadow loading and per-digit blinking.
// Ports:
//   clk, rst         clock, async active-high reset
//   en               scan enable (0: counters hold, anodes off)
//   load             request shadow capture at next frame boundary
//   hexs/points/les  live display data, one nibble/bit per digit
//   blink            per-digit blink enable
//   hex/p/le         registered data for the current digit
//   an               active-low anodes, at most one low
//   digit_idx        current digit index
//   frame_tick       one-cycle pulse after each frame wrap
module disp_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 64,
  localparam int IW          = $clog2(DIGITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] hexs,
  input  logic [DIGITS-1:0]   points,
  input  logic [DIGITS-1:0]   les,
  input  logic [DIGITS-1:0]   blink,
  output logic [3:0]          hex,
  output logic                p,
  output logic                le,
  output logic [DIGITS-1:0]   an,
  output logic [IW-1:0]       digit_idx,
  output logic                frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES) + 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          bph_q, bph_d;
  logic          pend_q, pend_d;

  logic [DIGITS-1:0][3:0] sh_hex_q, sh_hex_d;
  logic [DIGITS-1:0]      sh_pt_q, sh_pt_d;
  logic [DIGITS-1:0]      sh_le_q, sh_le_d;
  logic [DIGITS-1:0]      sh_bl_q, sh_bl_d;

  logic [3:0]        hex_q, hex_d;
  logic              p_q, p_d;
  logic              le_q, le_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [IW-1:0]     didx_q, didx_d;
  logic              tick_q, tick_d;

  logic slot_end;
  logic frame_end;
  logic in_blank;

  assign slot_end  = en && (cnt_q == CNT_MAX);
  assign frame_end = slot_end && (idx_q == IDX_MAX);

  // Zero dead time would make the compare constant-false.
  if (BLANK_CYC > 0) begin : g_blank
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYC);
    assign in_blank = (cnt_q < BLANK_C);
  end else begin : g_noblank
    assign in_blank = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      bph_q    <= 1'b0;
      pend_q   <= 1'b0;
      sh_hex_q <= '0;
      sh_pt_q  <= '0;
      sh_le_q  <= '0;
      sh_bl_q  <= '0;
      hex_q    <= '0;
      p_q      <= 1'b0;
      le_q     <= 1'b0;
      an_q     <= '1;
      didx_q   <= '0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      bph_q    <= bph_d;
      pend_q   <= pend_d;
      sh_hex_q <= sh_hex_d;
      sh_pt_q  <= sh_pt_d;
      sh_le_q  <= sh_le_d;
      sh_bl_q  <= sh_bl_d;
      hex_q    <= hex_d;
      p_q      <= p_d;
      le_q     <= le_d;
      an_q     <= an_d;
      didx_q   <= didx_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    bph_d    = bph_q;
    pend_d   = pend_q | load;
    sh_hex_d = sh_hex_q;
    sh_pt_d  = sh_pt_q;
    sh_le_d  = sh_le_q;
    sh_bl_d  = sh_bl_q;
    if (en) begin
      if (slot_end) begin
        cnt_d = '0;
        if (idx_q == IDX_MAX) idx_d = '0;
        else                  idx_d = idx_q + IW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (frame_end) begin
      if (bcnt_q == BLK_MAX) begin
        bcnt_d = '0;
        bph_d  = ~bph_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
      // A load in the boundary cycle itself still lands this frame.
      if (pend_q || load) begin
        sh_hex_d = hexs;
        sh_pt_d  = points;
        sh_le_d  = les;
        sh_bl_d  = blink;
      end
      pend_d = 1'b0;
    end
  end

  always_comb begin
    hex_d  = sh_hex_q[idx_q];
    p_d    = sh_pt_q[idx_q];
    le_d   = sh_le_q[idx_q];
    didx_d = idx_q;
    tick_d = frame_end;
    an_d   = ~(DIGITS'(1) << idx_q);
    if (in_blank || !en || (bph_q && sh_bl_q[idx_q]))
      an_d = '1;
  end

  assign hex        = hex_q;
  assign p          = p_q;
  assign le         = le_q;
  assign an         = an_q;
  assign digit_idx  = didx_q;
  assign frame_tick = tick_q;

endmodule
